// File: rtl/console_tx.sv
// Buffered memory-mapped console transmitter: TX FIFO feeding an 8N1 serial
// shifter with a fixed bit period, plus a pollable status register.
module console_tx #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DIVISOR    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  full;
  logic                  empty;
  logic                  ovf;

  state_t      state;
  state_t      state_d;
  logic [15:0] baud;
  logic [15:0] baud_d;
  logic [2:0]  bitidx;
  logic [2:0]  bitidx_d;
  logic [7:0]  shreg;
  logic [7:0]  shreg_d;
  logic        tx_d;
  logic        pop;

  logic        push_req;
  logic        push_ok;
  logic        ovf_set;
  logic        ovf_clr;
  logic [8:0]  count_ext;
  logic [7:0]  level;
  logic [31:0] status;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A push into a full FIFO is still accepted when the transmitter pops in
  // the same cycle; pointers never collide because the pop reads the old slot.
  assign push_req = cs & we & ~addr;
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & ~push_ok;
  assign ovf_clr  = cs & we & addr & wdata[2];

  always_comb begin
    count_d = count;
    case ({push_ok, pop})
      2'b10:   count_d = count + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count;
    endcase
  end

  always_comb begin
    count_ext = 9'(count);
    level     = count_ext[8] ? 8'hFF : count_ext[7:0];
    status    = {16'h0000, level, 4'h0, (state != S_IDLE), ovf, empty, full};
  end

  always_comb begin
    state_d  = state;
    baud_d   = baud;
    bitidx_d = bitidx;
    shreg_d  = shreg;
    tx_d     = 1'b1;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = mem[rptr];
          state_d = S_START;
          baud_d  = BAUD_RELOAD;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud == '0) begin
          state_d  = S_DATA;
          baud_d   = BAUD_RELOAD;
          bitidx_d = '0;
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      S_DATA: begin
        tx_d = shreg[0];
        if (baud == '0) begin
          baud_d = BAUD_RELOAD;
          if (bitidx == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitidx_d = bitidx + 3'd1;
            shreg_d  = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = mem[rptr];
            state_d = S_START;
            baud_d  = BAUD_RELOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      baud   <= '0;
      bitidx <= '0;
      shreg  <= '0;
      tx     <= 1'b1;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      irq    <= 1'b1;
      rdata  <= '0;
    end else begin
      state  <= state_d;
      baud   <= baud_d;
      bitidx <= bitidx_d;
      shreg  <= shreg_d;
      tx     <= tx_d;
      count  <= count_d;
      if (push_ok) begin
        wptr <= wptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rptr <= rptr + DEPTH_LOG2'(1);
      end
      ovf <= ovf_set | (ovf & ~ovf_clr);
      irq <= empty & (state == S_IDLE);
      if (cs & ~we) begin
        rdata <= addr ? status : '0;
      end
    end
  end

endmodule
